// File: rtl/sd4_accumulator.sv
// sd4_accumulator
//   Accumulates signed 20-bit adder-tree terms into one 24-bit signed
//   dot-product result, counts the terms and flags overflow. The result is
//   presented with a valid/ready handshake and held until consumed.
//
//   Optional feature: define SD4_ACC_SAT_EN to clamp the accumulator on
//   overflow. When it is undefined, the accumulator wraps (two's complement).
//   ovf is reported in both builds.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   sum_in     [19:0] signed term
//   in_valid   term valid
//   in_last    term is the final one of the current dot product
//   in_ready   block can accept a term this cycle
//   flush      abort the accumulation in progress (ignored while holding a result)
//   acc_out    [23:0] signed result, held while out_valid and after
//   term_cnt   [7:0] terms in the result, saturating at 255
//   ovf        24-bit signed range exceeded during accumulation
//   out_valid  result valid
//   out_ready  downstream consumes the result
module sd4_accumulator (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] sum_in,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        flush,
    output logic [23:0] acc_out,
    output logic [7:0]  term_cnt,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] acc_q, acc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ovf_r_q, ovf_r_d;
    logic [23:0] acc_out_q, acc_out_d;
    logic [7:0]  term_cnt_q, term_cnt_d;
    logic        ovf_q, ovf_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        first;
    logic [24:0] sum25;
    logic        sum_ovf;
    logic [23:0] acc_new;
    logic [7:0]  cnt_new;
    logic        ovf_new;

    assign in_ready = (state_q != HOLD) && !flush;
    assign accept   = in_valid && in_ready;
    assign first    = (state_q == IDLE);

    // In IDLE the first term starts from zero, so the old accumulator is masked.
    assign sum25   = (first ? 25'd0 : {acc_q[23], acc_q}) + {{5{sum_in[19]}}, sum_in};
    // The 25-bit sum leaves the 24-bit range exactly when its top two bits differ.
    assign sum_ovf = sum25[24] ^ sum25[23];

`ifdef SD4_ACC_SAT_EN
    assign acc_new = !sum_ovf ? sum25[23:0] :
                     (sum25[24] ? 24'h800000 : 24'h7fffff);
`else
    assign acc_new = sum25[23:0];
`endif

    assign cnt_new = first ? 8'd1 : ((cnt_q == 8'hff) ? 8'hff : cnt_q + 8'd1);
    // Sticky until the next IDLE accept restarts the dot product.
    assign ovf_new = (first ? 1'b0 : ovf_r_q) | sum_ovf;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_r_d     = ovf_r_q;
        acc_out_d   = acc_out_q;
        term_cnt_d  = term_cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (flush) begin
                    state_d = IDLE;
                    acc_d   = 24'd0;
                    cnt_d   = 8'd0;
                    ovf_r_d = 1'b0;
                end else if (accept) begin
                    acc_d   = acc_new;
                    cnt_d   = cnt_new;
                    ovf_r_d = ovf_new;
                    if (in_last) begin
                        state_d     = HOLD;
                        acc_out_d   = acc_new;
                        term_cnt_d  = cnt_new;
                        ovf_d       = ovf_new;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 24'd0;
            cnt_q       <= 8'd0;
            ovf_r_q     <= 1'b0;
            acc_out_q   <= 24'd0;
            term_cnt_q  <= 8'd0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_r_q     <= ovf_r_d;
            acc_out_q   <= acc_out_d;
            term_cnt_q  <= term_cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign acc_out   = acc_out_q;
    assign term_cnt  = term_cnt_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sd4_accumulator.sv
// Directed testbench for sd4_accumulator. Inputs change 1 time unit after a
// rising edge; outputs are sampled at the same point, so they reflect the
// state loaded by the preceding edge.
module tb_sd4_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [19:0] sum_in;
    logic        in_valid, in_last, in_ready, flush;
    logic [23:0] acc_out;
    logic [7:0]  term_cnt;
    logic        ovf, out_valid, out_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sd4_accumulator dut (
        .clk(clk), .rst_n(rst_n), .sum_in(sum_in), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .flush(flush),
        .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one term for one cycle, then drop in_valid.
    task automatic send_term(input int v, input logic last);
        sum_in   = 20'(v);
        in_valid = 1'b1;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        sum_in = '0; out_ready = 1'b1;
        step(); step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (acc_out !== 24'd0) $display("FAIL reset_acc_out got %0d want 0", $signed(acc_out)); else n_pass++;
        n_total++; if (term_cnt !== 8'd0) $display("FAIL reset_term_cnt got %0d want 0", term_cnt); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
        rst_n = 1'b1;
        step();
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_term(100, 1'b0);
        send_term(-30, 1'b0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", out_valid); else n_pass++;
        send_term(7, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", out_valid); else n_pass++;
        n_total++; if (acc_out !== 24'd77) $display("FAIL basic_acc got %0d want 77", $signed(acc_out)); else n_pass++;
        n_total++; if (term_cnt !== 8'd3) $display("FAIL basic_cnt got %0d want 3", term_cnt); else n_pass++;
        n_total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b0) $display("FAIL basic_consume got %b want 0", out_valid); else n_pass++;
        n_total++; if (acc_out !== 24'd77) $display("FAIL basic_retain got %0d want 77", $signed(acc_out)); else n_pass++;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        send_term(3, 1'b1);
        in_valid = 1'b1; sum_in = 20'd1000; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1 || acc_out !== 24'd3 || term_cnt !== 8'd1)
                $display("FAIL hold_stable[%0d] got v=%b acc=%0d cnt=%0d want v=1 acc=3 cnt=1",
                         i, out_valid, $signed(acc_out), term_cnt);
            else n_pass++;
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL hold_release got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL hold_idle_ready got %b want 1", in_ready); else n_pass++;
        // If a held-input term had been taken, this result would not be 4/1.
        send_term(4, 1'b1);
        n_total++; if (acc_out !== 24'd4 || term_cnt !== 8'd1)
            $display("FAIL hold_next got acc=%0d cnt=%0d want acc=4 cnt=1", $signed(acc_out), term_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_overflow();
        int exp_pos, exp_neg;
`ifdef SD4_ACC_SAT_EN
        exp_pos = 8388607;  exp_neg = -8388608;
`else
        exp_pos = -7864337; exp_neg = 7864320;   // 17*524287 - 2^24, -17*524288 + 2^24
`endif
        out_ready = 1'b1;
        // 16 * 524287 = 8388592 still fits in 24 bits.
        for (int i = 0; i < 16; i++) send_term(524287, i == 15);
        n_total++; if (acc_out !== 24'(8388592) || ovf !== 1'b0)
            $display("FAIL ovf_16 got acc=%0d ovf=%b want acc=8388592 ovf=0", $signed(acc_out), ovf);
        else n_pass++;
        step();
        for (int i = 0; i < 17; i++) send_term(524287, i == 16);
        n_total++; if (acc_out !== 24'(exp_pos) || ovf !== 1'b1 || term_cnt !== 8'd17)
            $display("FAIL ovf_pos got acc=%0d ovf=%b cnt=%0d want acc=%0d ovf=1 cnt=17",
                     $signed(acc_out), ovf, term_cnt, exp_pos);
        else n_pass++;
        step();
        for (int i = 0; i < 17; i++) send_term(-524288, i == 16);
        n_total++; if (acc_out !== 24'(exp_neg) || ovf !== 1'b1)
            $display("FAIL ovf_neg got acc=%0d ovf=%b want acc=%0d ovf=1", $signed(acc_out), ovf, exp_neg);
        else n_pass++;
        step();
        send_term(5, 1'b1);
        n_total++; if (ovf !== 1'b0 || acc_out !== 24'd5)
            $display("FAIL ovf_clear got acc=%0d ovf=%b want acc=5 ovf=0", $signed(acc_out), ovf);
        else n_pass++;
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send_term(50, 1'b0);
        send_term(60, 1'b0);
        flush = 1'b1; in_valid = 1'b1; sum_in = 20'd9;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else n_pass++;
        step();
        flush = 1'b0; in_valid = 1'b0;
        send_term(5, 1'b1);
        n_total++; if (acc_out !== 24'd5 || term_cnt !== 8'd1)
            $display("FAIL flush_after got acc=%0d cnt=%0d want acc=5 cnt=1", $signed(acc_out), term_cnt);
        else n_pass++;
        step();
        // flush must not discard a held result
        out_ready = 1'b0;
        send_term(8, 1'b1);
        flush = 1'b1;
        step(); step();
        flush = 1'b0;
        n_total++; if (out_valid !== 1'b1 || acc_out !== 24'd8)
            $display("FAIL flush_hold got v=%b acc=%0d want v=1 acc=8", out_valid, $signed(acc_out));
        else n_pass++;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_count_sat();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send_term(1, i == 299);
        n_total++; if (acc_out !== 24'd300 || term_cnt !== 8'd255)
            $display("FAIL cnt_sat got acc=%0d cnt=%0d want acc=300 cnt=255", $signed(acc_out), term_cnt);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send_term(1, 1'b0);
        send_term(2, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_total++; if (out_valid !== 1'b0 || acc_out !== 24'd0 || term_cnt !== 8'd0 || ovf !== 1'b0)
            $display("FAIL rst_accum got v=%b acc=%0d cnt=%0d ovf=%b want all 0",
                     out_valid, $signed(acc_out), term_cnt, ovf);
        else n_pass++;
        send_term(4, 1'b1);
        n_total++; if (acc_out !== 24'd4 || term_cnt !== 8'd1)
            $display("FAIL rst_accum_idle got acc=%0d cnt=%0d want acc=4 cnt=1", $signed(acc_out), term_cnt);
        else n_pass++;
        step();
        out_ready = 1'b0;
        send_term(6, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_total++; if (out_valid !== 1'b0 || acc_out !== 24'd0 || term_cnt !== 8'd0)
            $display("FAIL rst_hold got v=%b acc=%0d cnt=%0d want all 0", out_valid, $signed(acc_out), term_cnt);
        else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_hold_ready got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_flush();
        test_count_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
